net_interface: RTL and testbench

NET_INTERFACE -- requirements
Module: net_interface

---
 rtl/net_interface.sv | 159 +++++++++++++++
 tb/tb_net_interface.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/net_interface.sv
// net_interface: CPU-side network port bridging a CPU MEM stage to a router.
//
// Two independent DEPTH x 32 FIFOs:
//   TX: the CPU pushes (NET_WRITE) and the router pops via TX_VALID/TX_READY.
//   RX: the router pushes via RX_VALID/RX_READY and the CPU pops (NET_READ).
// CPU reads are zero-latency. A read on an empty RX FIFO stalls the CPU
// (NET_BUSYWAIT). If nothing arrives within RD_TIMEOUT stall cycles, the CPU
// is released with 32'hFFFF_FFFF.
//
// Ports:
//   CLK, RESET            clock; synchronous active-low reset
//   NET_WRITE/_DATA       CPU send request and packet word
//   NET_READ/_DATA        CPU receive request and packet word (combinational)
//   NET_BUSYWAIT          CPU stall (write to a full TX FIFO or blocked read)
//   TX_VALID/DATA/READY   router-bound stream
//   RX_VALID/DATA/READY   router-sourced stream
//   RX_COUNT              registered RX occupancy
module net_interface #(
    parameter int DEPTH      = 4,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       NET_WRITE,
    input  logic [31:0]                NET_WRITE_DATA,
    input  logic                       NET_READ,
    output logic [31:0]                NET_READ_DATA,
    output logic                       NET_BUSYWAIT,
    output logic                       TX_VALID,
    output logic [31:0]                TX_DATA,
    input  logic                       TX_READY,
    input  logic                       RX_VALID,
    input  logic [31:0]                RX_DATA,
    output logic                       RX_READY,
    output logic [$clog2(DEPTH):0]     RX_COUNT
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(RD_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TIMEOUT} state_t;

    logic [31:0]   tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [CW-1:0] tx_count_reg;
    logic [31:0]   rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [CW-1:0] rx_count_reg;

    state_t        state_reg, state_next;
    logic [WW-1:0] wait_cnt_reg, wait_cnt_next;

    logic tx_full, tx_push, tx_pop;
    logic rx_full, rx_empty, rx_push, rx_pop;
    logic read_stall, read_timeout;

    assign tx_full  = (tx_count_reg == CW'(DEPTH));
    assign rx_full  = (rx_count_reg == CW'(DEPTH));
    assign rx_empty = (rx_count_reg == '0);

    // A full TX FIFO still accepts a write on the edge the router drains it.
    assign tx_pop  = TX_VALID && TX_READY;
    assign tx_push = NET_WRITE && (!tx_full || tx_pop);
    assign rx_push = RX_VALID && RX_READY;
    // The timeout cycle releases the CPU with a dummy word and never consumes data.
    assign rx_pop  = NET_READ && !rx_empty && (state_reg != S_TIMEOUT);

    assign TX_VALID      = (tx_count_reg != '0);
    assign TX_DATA       = tx_mem[tx_rd_ptr_reg];
    assign RX_READY      = !rx_full;
    assign RX_COUNT      = rx_count_reg;
    assign NET_READ_DATA = read_timeout ? 32'hFFFF_FFFF : rx_mem[rx_rd_ptr_reg];
    assign NET_BUSYWAIT  = (NET_WRITE && tx_full && !TX_READY) || read_stall;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) tx_mem[i] <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr_ptr_reg] <= NET_WRITE_DATA;
                tx_wr_ptr_reg         <= tx_wr_ptr_reg + 1'b1;
            end
            if (tx_pop) tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count_reg <= tx_count_reg + 1'b1;
                2'b01:   tx_count_reg <= tx_count_reg - 1'b1;
                default: tx_count_reg <= tx_count_reg;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) rx_mem[i] <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr_ptr_reg] <= RX_DATA;
                rx_wr_ptr_reg         <= rx_wr_ptr_reg + 1'b1;
            end
            if (rx_pop) rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count_reg <= rx_count_reg + 1'b1;
                2'b01:   rx_count_reg <= rx_count_reg - 1'b1;
                default: rx_count_reg <= rx_count_reg;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // The IDLE cycle that discovers the empty FIFO is itself a stall cycle,
    // so WAIT ends one count early to give RD_TIMEOUT stall cycles in total.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        read_stall    = 1'b0;
        read_timeout  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (NET_READ && rx_empty) begin
                    read_stall    = 1'b1;
                    state_next    = S_WAIT;
                    wait_cnt_next = '0;
                end
            end
            S_WAIT: begin
                if (!NET_READ || !rx_empty) begin
                    state_next = S_IDLE;
                end else begin
                    read_stall = 1'b1;
                    if (wait_cnt_reg == WW'(RD_TIMEOUT - 2)) begin
                        state_next = S_TIMEOUT;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                    end
                end
            end
            S_TIMEOUT: begin
                read_timeout = 1'b1;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_net_interface.sv
// Self-checking bench for net_interface. A negedge monitor keeps TX and RX
// scoreboards: words are queued when a push is accepted and popped and compared
// when the router or the CPU consumes them. The main flow checks stall timing,
// flags and reset behaviour.
module tb_net_interface;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        NET_WRITE;
    logic [31:0] NET_WRITE_DATA;
    logic        NET_READ;
    logic [31:0] NET_READ_DATA;
    logic        NET_BUSYWAIT;
    logic        TX_VALID;
    logic [31:0] TX_DATA;
    logic        TX_READY;
    logic        RX_VALID;
    logic [31:0] RX_DATA;
    logic        RX_READY;
    logic [2:0]  RX_COUNT;

    int checks   = 0;
    int failures = 0;
    logic [31:0] tx_exp[$];
    logic [31:0] rx_exp[$];

    net_interface #(.DEPTH(4), .RD_TIMEOUT(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .NET_WRITE(NET_WRITE), .NET_WRITE_DATA(NET_WRITE_DATA),
        .NET_READ(NET_READ), .NET_READ_DATA(NET_READ_DATA),
        .NET_BUSYWAIT(NET_BUSYWAIT),
        .TX_VALID(TX_VALID), .TX_DATA(TX_DATA), .TX_READY(TX_READY),
        .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_READY(RX_READY),
        .RX_COUNT(RX_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Inputs change just after posedge, so they are stable here.
    always @(negedge CLK) begin
        if (RESET) begin
            if (TX_VALID && TX_READY) begin
                if (tx_exp.size() == 0) check("tx_unexpected_pop", 32'(tx_exp.size()), 32'd1);
                else check("tx_word", TX_DATA, tx_exp.pop_front());
            end
            if (NET_WRITE && !NET_BUSYWAIT) tx_exp.push_back(NET_WRITE_DATA);
            // A read released with nothing queued can only be a timeout.
            if (NET_READ && !NET_BUSYWAIT) begin
                if (rx_exp.size() == 0) check("rd_timeout_word", NET_READ_DATA, 32'hFFFF_FFFF);
                else check("rd_word", NET_READ_DATA, rx_exp.pop_front());
            end
            if (RX_VALID && RX_READY) rx_exp.push_back(RX_DATA);
        end
    end

    task automatic drain_tx();
        TX_READY = 1'b1;
        for (int i = 0; i < 20 && TX_VALID; i++) tick();
        TX_READY = 1'b0;
        #1;
        check("tx_drained_valid", 32'(TX_VALID), 32'd0);
        check("tx_sb_empty", 32'(tx_exp.size()), 32'd0);
    endtask

    initial begin
        int busy_n;
        RESET = 1'b0; NET_WRITE = 1'b0; NET_WRITE_DATA = '0; NET_READ = 1'b0;
        TX_READY = 1'b0; RX_VALID = 1'b0; RX_DATA = '0;
        tick(); tick();
        check("rst_tx_valid", 32'(TX_VALID), 32'd0);
        check("rst_rx_ready", 32'(RX_READY), 32'd1);
        check("rst_rx_count", 32'(RX_COUNT), 32'd0);
        check("rst_busy", 32'(NET_BUSYWAIT), 32'd0);
        check("rst_rd_data", NET_READ_DATA, 32'h0);
        check("rst_tx_data", TX_DATA, 32'h0);
        RESET = 1'b1;
        tick();

        // TX fill, stall on the 5th write, release by one router pop.
        for (int i = 1; i <= 4; i++) begin
            NET_WRITE = 1'b1; NET_WRITE_DATA = 32'hA5A5_0000 + i;
            tick();
        end
        NET_WRITE_DATA = 32'hA5A5_0005;
        #1;
        check("tx_full_valid", 32'(TX_VALID), 32'd1);
        check("tx_head", TX_DATA, 32'hA5A5_0001);
        check("tx_full_busy", 32'(NET_BUSYWAIT), 32'd1);
        tick();
        check("tx_full_busy_held", 32'(NET_BUSYWAIT), 32'd1);
        check("tx_head_stable", TX_DATA, 32'hA5A5_0001);
        TX_READY = 1'b1;
        #1;
        check("tx_release_busy", 32'(NET_BUSYWAIT), 32'd0);
        tick();
        NET_WRITE = 1'b0; TX_READY = 1'b0;
        #1;
        check("tx_after_release_head", TX_DATA, 32'hA5A5_0002);
        drain_tx();

        // RX fill to full, then four back-to-back zero-latency reads.
        for (int i = 0; i < 4; i++) begin
            RX_VALID = 1'b1; RX_DATA = 32'h10 + i;
            tick();
        end
        RX_VALID = 1'b0;
        #1;
        check("rx_full_ready", 32'(RX_READY), 32'd0);
        check("rx_full_count", 32'(RX_COUNT), 32'd4);
        NET_READ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rx_read_busy", 32'(NET_BUSYWAIT), 32'd0);
            tick();
        end
        NET_READ = 1'b0;
        #1;
        check("rx_empty_count", 32'(RX_COUNT), 32'd0);

        // Blocked read satisfied by a late arrival.
        NET_READ = 1'b1;
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!NET_BUSYWAIT) break;
            busy_n++;
            if (busy_n == 5) begin RX_VALID = 1'b1; RX_DATA = 32'h0000_00AB; end
            tick();
            RX_VALID = 1'b0;
        end
        check("late_busy_cycles", 32'(busy_n), 32'd5);
        check("late_data", NET_READ_DATA, 32'h0000_00AB);
        tick();
        NET_READ = 1'b0;
        #1;
        check("late_rx_count", 32'(RX_COUNT), 32'd0);

        // Blocked read released by the timeout.
        NET_READ = 1'b1;
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!NET_BUSYWAIT) break;
            busy_n++;
            tick();
        end
        check("to_busy_cycles", 32'(busy_n), 32'd16);
        check("to_data", NET_READ_DATA, 32'hFFFF_FFFF);
        tick();
        NET_READ = 1'b0;
        #1;
        check("to_after_busy", 32'(NET_BUSYWAIT), 32'd0);

        // Write into a full TX FIFO on the same edge the router pops.
        for (int i = 0; i < 4; i++) begin
            NET_WRITE = 1'b1; NET_WRITE_DATA = 32'hB0 + i;
            tick();
        end
        NET_WRITE_DATA = 32'hB4; TX_READY = 1'b1;
        #1;
        check("simul_busy", 32'(NET_BUSYWAIT), 32'd0);
        tick();
        TX_READY = 1'b0; NET_WRITE_DATA = 32'hB5;
        #1;
        check("simul_still_full", 32'(NET_BUSYWAIT), 32'd1);
        check("simul_head", TX_DATA, 32'hB1);
        NET_WRITE = 1'b0;
        drain_tx();

        // Reset during a blocked read with TX data held.
        for (int i = 0; i < 2; i++) begin
            NET_WRITE = 1'b1; NET_WRITE_DATA = 32'hC0 + i;
            tick();
        end
        NET_WRITE = 1'b0; NET_READ = 1'b1;
        tick(); tick(); tick();
        check("midwait_busy", 32'(NET_BUSYWAIT), 32'd1);
        RESET = 1'b0; NET_READ = 1'b0;
        tx_exp.delete(); rx_exp.delete();
        tick();
        check("rstw_tx_valid", 32'(TX_VALID), 32'd0);
        check("rstw_rx_count", 32'(RX_COUNT), 32'd0);
        check("rstw_busy", 32'(NET_BUSYWAIT), 32'd0);
        RESET = 1'b1;
        RX_VALID = 1'b1; RX_DATA = 32'h0000_00D1;
        tick();
        RX_VALID = 1'b0; NET_READ = 1'b1;
        #1;
        check("rstw_idle_read_busy", 32'(NET_BUSYWAIT), 32'd0);
        check("rstw_idle_read_data", NET_READ_DATA, 32'h0000_00D1);
        tick();
        NET_READ = 1'b0;
        tick();
        check("final_rx_sb_empty", 32'(rx_exp.size()), 32'd0);
        check("final_tx_sb_empty", 32'(tx_exp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
